// File: rtl/race_ctrl_pkg.sv
// Shared types and constants for the race start/finish controller.
package race_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READY  = 3'd1,
    S_SET    = 3'd2,
    S_GO     = 3'd3,
    S_TIMING = 3'd4,
    S_REPORT = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

  // semaforo bit order is {Verde, Amarillo, Rojo}
  localparam logic [2:0] SEM_OFF = 3'b000;
  localparam logic [2:0] SEM_RED = 3'b001;
  localparam logic [2:0] SEM_YEL = 3'b010;
  localparam logic [2:0] SEM_GRN = 3'b100;

  // Largest of the three phase lengths; sizes the shared phase down-counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/edge_detect_vec.sv
// Registered rising-edge detector: rise[i] is high for one cycle, the cycle
// after d[i] is first sampled high.
module edge_detect_vec #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev_q, prev_d;
  logic [W-1:0] rise_q, rise_d;

  // Compare the current sample with the previous one.
  always_comb begin
    prev_d = d;
    rise_d = d & ~prev_q;
  end

  // History and edge registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      rise_q <= '0;
    end else begin
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/race_control_fsm.sv
// Multi-lane race sequencer: light sequence, per-lane finish capture,
// all-finished/timeout end of race and UART report handshake.
// Optional macro FALSE_START_EN: a starting block released during SET
// sends the sequencer to FAULT; without it block_in is ignored and
// fault_out stays 0.
module race_control_fsm
  import race_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 25_000_000,
  parameter int unsigned N_LANES     = 4,
  parameter int unsigned COUNT_READY = CLK_FREQ * 2,
  parameter int unsigned COUNT_SET   = CLK_FREQ * 2,
  parameter int unsigned COUNT_GO    = CLK_FREQ * 1,
  parameter int unsigned COUNT_MAX   = CLK_FREQ * 60
) (
  input  logic               clk,
  input  logic               reset_global,
  input  logic               set_button_in,
  input  logic [N_LANES-1:0] sensor_meta_in,
  input  logic [N_LANES-1:0] block_in,
  input  logic               uart_ack_in,
  output logic               reset_timer_out,
  output logic               enable_timer_out,
  output logic [2:0]         semaforo_out,
  output logic               servo_out,
  output logic [N_LANES-1:0] lane_capture_out,
  output logic [N_LANES-1:0] lane_done_out,
  output logic               timeout_out,
  output logic               fault_out,
  output logic               uart_req_out
);

  localparam int unsigned CW = $clog2(max3(COUNT_READY, COUNT_SET, COUNT_GO) + 1);
  localparam int unsigned RW = $clog2(COUNT_MAX + 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [RW-1:0]      race_q, race_d;
  logic [N_LANES-1:0] cap_q, cap_d;
  logic [N_LANES-1:0] done_q, done_d;
  logic               tmo_q, tmo_d;

  logic [N_LANES:0]   rise;
  logic               set_rise;
  logic [N_LANES-1:0] sens_rise;
  logic               in_race;

  edge_detect_vec #(.W(N_LANES + 1)) u_edge (
    .clk  (clk),
    .rst  (reset_global),
    .d    ({sensor_meta_in, set_button_in}),
    .rise (rise)
  );

  assign set_rise  = rise[0];
  assign sens_rise = rise[N_LANES:1];
  assign in_race   = (state_q == S_GO) || (state_q == S_TIMING);

`ifdef FALSE_START_EN
  logic [N_LANES-1:0] blk_q, blk_d;
  logic               fault_q, fault_d;
  logic               blk_fall;

  assign blk_d    = block_in;
  assign blk_fall = |(blk_q & ~block_in);

  // Fault flag: raised on the SET->FAULT jump, cleared when a new start begins.
  always_comb begin
    fault_d = fault_q;
    if (state_q == S_SET && state_d == S_FAULT)       fault_d = 1'b1;
    else if (state_q == S_IDLE && state_d == S_READY) fault_d = 1'b0;
  end

  // Block history and fault flag registers.
  always_ff @(posedge clk) begin
    if (reset_global) begin
      blk_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      blk_q   <= blk_d;
      fault_q <= fault_d;
    end
  end

  assign fault_out = fault_q;
`else
  logic unused_block;
  assign unused_block = ^block_in;
  assign fault_out    = 1'b0;
`endif

  // Next state, phase counter, race counter and per-lane finish tracking.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    race_d  = race_q;
    cap_d   = '0;
    done_d  = done_q | cap_q;
    tmo_d   = tmo_q;
    if (in_race) begin
      // a lane is captured once; a pending strobe counts as finished
      cap_d  = sens_rise & ~(done_q | cap_q);
      race_d = race_q + RW'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (set_rise) begin
          state_d = S_READY;
          cnt_d   = CW'(COUNT_READY - 1);
          done_d  = '0;
          tmo_d   = 1'b0;
        end
      end
      S_READY: begin
        if (set_rise) state_d = S_IDLE;
        else if (cnt_q == '0) begin
          state_d = S_SET;
          cnt_d   = CW'(COUNT_SET - 1);
        end else cnt_d = cnt_q - CW'(1);
      end
      S_SET: begin
        if (set_rise) state_d = S_IDLE;
`ifdef FALSE_START_EN
        else if (blk_fall) state_d = S_FAULT;
`endif
        else if (cnt_q == '0) begin
          state_d = S_GO;
          cnt_d   = CW'(COUNT_GO - 1);
          race_d  = RW'(1);
        end else cnt_d = cnt_q - CW'(1);
      end
      S_GO: begin
        if (cnt_q == '0) state_d = S_TIMING;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_TIMING: begin
        if (done_q == '1) state_d = S_REPORT;
        else if (race_q == RW'(COUNT_MAX)) begin
          state_d = S_REPORT;
          tmo_d   = 1'b1;
        end
      end
      S_REPORT: if (uart_ack_in) state_d = S_IDLE;
      S_FAULT:  if (set_rise)    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and counters; reset returns to IDLE even mid-race.
  always_ff @(posedge clk) begin
    if (reset_global) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      race_q  <= '0;
      cap_q   <= '0;
      done_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      race_q  <= race_d;
      cap_q   <= cap_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  // Moore decode of the lights, timer controls and report request.
  always_comb begin
    reset_timer_out  = 1'b0;
    enable_timer_out = 1'b0;
    semaforo_out     = SEM_OFF;
    servo_out        = 1'b0;
    uart_req_out     = 1'b0;
    case (state_q)
      S_IDLE:   reset_timer_out = 1'b1;
      S_READY:  semaforo_out    = SEM_RED;
      S_SET:    semaforo_out    = SEM_YEL;
      S_GO: begin
        semaforo_out     = SEM_GRN;
        servo_out        = 1'b1;
        enable_timer_out = 1'b1;
      end
      S_TIMING: enable_timer_out = 1'b1;
      S_REPORT: uart_req_out     = 1'b1;
      S_FAULT: begin
        semaforo_out    = SEM_RED;
        reset_timer_out = 1'b1;
      end
      default: ;
    endcase
  end

  assign lane_capture_out = cap_q;
  assign lane_done_out    = done_q;
  assign timeout_out      = tmo_q;

endmodule
